// File: rtl/v9958_bus_bridge_pkg.sv
// Shared VDP definitions: I/O port map, bridge FSM states and default decode bases.
`timescale 1ns/1ps
package v9958_bus_bridge_pkg;

  // vdp_constants: Z80 I/O ports of the V9958
  localparam logic [7:0] VDP_PORT_VRAM = 8'h98;
  localparam logic [7:0] VDP_PORT_CTRL = 8'h99;
  localparam logic [7:0] VDP_PORT_PAL  = 8'h9A;
  localparam logic [7:0] VDP_PORT_IREG = 8'h9B;
  localparam logic [7:0] AUX_PORT_LED  = 8'h9C;

  localparam logic [5:0] VDP_BASE_DEFAULT = 6'h26;
  localparam logic [5:0] AUX_BASE_DEFAULT = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_HOLD = 2'd3
  } bridge_state_e;

  // Decode group of a port: the four ports sharing A[7:2]
  function automatic logic [5:0] port_group(input logic [7:0] port);
    return port[7:2];
  endfunction

endpackage

// File: rtl/v9958_bus_bridge_strobe_sync.sv
// N-stage synchronizer for an active-low Z80 strobe; resets to the inactive level.
`timescale 1ns/1ps
module strobe_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  // Shift the raw strobe through N flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '1;
    else          r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/v9958_bus_bridge.sv
// Z80 I/O bus to VDP/aux bridge: synchronizes strobes, decodes A[7:2] and issues
// one-clk requests; read data is held on the pad until the strobes release.
`timescale 1ns/1ps
module v9958_bus_bridge
  import v9958_bus_bridge_pkg::*;
#(
  parameter logic [5:0] VDP_BASE    = VDP_BASE_DEFAULT,
  parameter logic [5:0] AUX_BASE    = AUX_BASE_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] A,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] cd_in,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  output logic       cs_n,
  output logic       vdp_req,
  output logic       aux_req,
  output logic       io_wr,
  output logic [7:0] io_wdata,
  input  logic [7:0] vdp_rdata,
  input  logic [7:0] aux_rdata
);

  logic w_iorq_n, w_rd_n, w_wr_n;
  logic w_rd_act, w_wr_act, w_cyc_act, w_cyc_seen, w_settled, w_start;
  logic w_vdp_hit, w_aux_hit, w_hit, w_go_req;
  logic [SYNC_STAGES-1:0] r_settle;
  logic r_cyc_q1, r_cyc_q2, r_wr_q1, r_sel_vdp;
  logic [7:0] r_cd_out, r_io_wdata;
  logic r_cd_oe, r_cs_n, r_vdp_req, r_aux_req, r_io_wr;
  bridge_state_e r_state, w_next;

  strobe_sync #(.N(SYNC_STAGES)) u_sync_iorq (.clk(clk), .reset_n(reset_n), .i_d(iorq_n), .o_q(w_iorq_n));
  strobe_sync #(.N(SYNC_STAGES)) u_sync_rd   (.clk(clk), .reset_n(reset_n), .i_d(rd_n),   .o_q(w_rd_n));
  strobe_sync #(.N(SYNC_STAGES)) u_sync_wr   (.clk(clk), .reset_n(reset_n), .i_d(wr_n),   .o_q(w_wr_n));

  assign w_rd_act  = ~w_iorq_n & ~w_rd_n &  w_wr_n;
  assign w_wr_act  = ~w_iorq_n & ~w_wr_n &  w_rd_n;
  assign w_cyc_act = w_rd_act | w_wr_act;

  // Until the synchronizers hold real pad samples after reset, treat the bus as busy
  // so strobes already active at release never look like a fresh rising edge.
  assign w_settled  = r_settle[SYNC_STAGES-1];
  assign w_cyc_seen = w_settled ? w_cyc_act : 1'b1;
  assign w_start    = r_cyc_q1 & ~r_cyc_q2;

  assign w_vdp_hit = (A == VDP_BASE);
  assign w_aux_hit = (A == AUX_BASE) & ~w_vdp_hit;
  assign w_hit     = w_vdp_hit | w_aux_hit;
  assign w_go_req  = (r_state == ST_IDLE) & w_start & w_hit;

  // Post-reset settle shifter and registered cycle-edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_settle <= '0;
      r_cyc_q1 <= 1'b1;
      r_cyc_q2 <= 1'b1;
      r_wr_q1  <= 1'b0;
    end else begin
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_cyc_q1 <= w_cyc_seen;
      r_cyc_q2 <= r_cyc_q1;
      r_wr_q1  <= w_wr_act;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = w_hit ? ST_REQ : ST_HOLD;
        else         w_next = ST_IDLE;
      end
      ST_REQ:  w_next = r_io_wr ? ST_HOLD : ST_CAPT;
      ST_CAPT: w_next = ST_HOLD;
      ST_HOLD: begin
        if (!w_cyc_act) w_next = ST_IDLE;
        else            w_next = ST_HOLD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered outputs, driven from the transition being taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vdp_req  <= 1'b0;
      r_aux_req  <= 1'b0;
      r_io_wr    <= 1'b0;
      r_io_wdata <= 8'h00;
      r_sel_vdp  <= 1'b0;
      r_cs_n     <= 1'b1;
      r_cd_oe    <= 1'b0;
      r_cd_out   <= 8'h00;
    end else begin
      r_vdp_req <= w_go_req & w_vdp_hit;
      r_aux_req <= w_go_req & w_aux_hit;
      if (w_go_req) begin
        r_io_wr    <= r_wr_q1;
        r_io_wdata <= cd_in;
        r_sel_vdp  <= w_vdp_hit;
      end
      if (w_next == ST_IDLE) r_cs_n <= 1'b1;
      else if (w_go_req)     r_cs_n <= 1'b0;
      if (w_next == ST_IDLE)                            r_cd_oe <= 1'b0;
      else if (r_state == ST_REQ && w_next == ST_CAPT)  r_cd_oe <= 1'b1;
      // Sampled again in CAPT, once the target has had a full clk to respond
      if (r_state == ST_REQ || r_state == ST_CAPT)
        r_cd_out <= r_sel_vdp ? vdp_rdata : aux_rdata;
    end
  end

  assign cd_out   = r_cd_out;
  assign cd_oe    = r_cd_oe;
  assign cs_n     = r_cs_n;
  assign vdp_req  = r_vdp_req;
  assign aux_req  = r_aux_req;
  assign io_wr    = r_io_wr;
  assign io_wdata = r_io_wdata;

endmodule

// File: tb/tb_v9958_bus_bridge.sv
// Directed bench for v9958_bus_bridge with a request scoreboard; a second instance
// with VDP_BASE == AUX_BASE checks that the VDP wins the decode.
`timescale 1ns/1ps
module tb_v9958_bus_bridge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] A;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] cd_in, vdp_rdata, aux_rdata;
  logic [7:0] cd_out, io_wdata;
  logic       cd_oe, cs_n, vdp_req, aux_req, io_wr;
  logic [7:0] cd_out2, io_wdata2;
  logic       cd_oe2, cs_n2, vdp_req2, aux_req2, io_wr2;

  typedef struct {
    logic       is_aux;
    logic       wr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vdp_cnt = 0, aux_cnt = 0, vdp2_cnt = 0, aux2_cnt = 0;

  always #5 clk = ~clk;

  v9958_bus_bridge dut (
    .clk(clk), .reset_n(reset_n), .A(A), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .cs_n(cs_n),
    .vdp_req(vdp_req), .aux_req(aux_req), .io_wr(io_wr), .io_wdata(io_wdata),
    .vdp_rdata(vdp_rdata), .aux_rdata(aux_rdata)
  );

  v9958_bus_bridge #(.VDP_BASE(6'h26), .AUX_BASE(6'h26)) dut_same (
    .clk(clk), .reset_n(reset_n), .A(A), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .cd_in(cd_in), .cd_out(cd_out2), .cd_oe(cd_oe2), .cs_n(cs_n2),
    .vdp_req(vdp_req2), .aux_req(aux_req2), .io_wr(io_wr2), .io_wdata(io_wdata2),
    .vdp_rdata(vdp_rdata), .aux_rdata(aux_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then score any request pulse seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (vdp_req2 === 1'b1) vdp2_cnt++;
    if (aux_req2 === 1'b1) aux2_cnt++;
    if (vdp_req === 1'b1 || aux_req === 1'b1) begin
      if (vdp_req === 1'b1) vdp_cnt++;
      if (aux_req === 1'b1) aux_cnt++;
      check("req_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("req_target", {vdp_req, aux_req}, e.is_aux ? 2'b01 : 2'b10);
        check("req_io_wr", io_wr, e.wr);
        check("req_wdata", io_wdata, e.data);
        check("req_cs_n", cs_n, 0);
      end
    end
  endtask

  task automatic idle_bus();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  initial begin
    int first, cs_bad, oe_bad, base, base2;
    logic [7:0] oe_hist;
    logic [7:0] out_at5;

    // Reset state
    reset_n = 1'b0; idle_bus(); A = 6'h00; cd_in = 8'h00;
    vdp_rdata = 8'h00; aux_rdata = 8'h00;
    repeat (3) tick();
    check("rst_cd_out", cd_out, 8'h00);
    check("rst_cd_oe", cd_oe, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_reqs", {vdp_req, aux_req, io_wr}, 3'b000);
    check("rst_wdata", io_wdata, 8'h00);
    reset_n = 1'b1;
    repeat (4) tick();

    // Write 0x98 <- 0x5A, strobes held 10 clk
    exp_q.push_back('{1'b0, 1'b1, 8'h5A});
    base = vdp_cnt + aux_cnt; base2 = vdp2_cnt;
    A = 6'h26; cd_in = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    first = 0; cs_bad = 0; oe_bad = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if ((vdp_req === 1'b1) && first == 0) first = i;
      if (i >= 4 && cs_n !== 1'b0) cs_bad++;
      if (cd_oe !== 1'b0) oe_bad++;
    end
    check("wr_latency", first, 4);
    check("wr_cs_low", cs_bad, 0);
    check("wr_oe_low", oe_bad, 0);
    idle_bus();
    repeat (5) tick();
    check("wr_one_req", vdp_cnt + aux_cnt - base, 1);
    check("same_base_vdp_wins", vdp2_cnt - base2, 1);
    check("wr_cs_release", cs_n, 1);

    // Read 0x99 with VDP data 0xC3
    exp_q.push_back('{1'b0, 1'b0, 8'h11});
    A = 6'h26; cd_in = 8'h11; vdp_rdata = 8'hC3; aux_rdata = 8'h3C;
    iorq_n = 1'b0; rd_n = 1'b0;
    oe_hist = 8'h00; out_at5 = 8'h00; first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if ((vdp_req === 1'b1) && first == 0) first = i;
      if (i <= 8) oe_hist[i-1] = cd_oe;
      if (i == 5) out_at5 = cd_out;
    end
    check("rd_latency", first, 4);
    check("rd_oe_during_req", oe_hist[3], 0);
    check("rd_oe_next_clk", oe_hist[4], 1);
    check("rd_cd_out", out_at5, 8'hC3);
    check("rd_oe_held", cd_oe, 1);
    idle_bus();
    tick();
    check("rd_oe_after_release", cd_oe, 1);
    repeat (2) tick();
    check("rd_oe_drop", cd_oe, 0);
    check("rd_cs_drop", cs_n, 1);
    repeat (3) tick();

    // Undecoded port 0x40, then aux port 0x9C
    base = vdp_cnt + aux_cnt;
    A = 6'h10; cd_in = 8'h40; iorq_n = 1'b0; wr_n = 1'b0;
    cs_bad = 0; oe_bad = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cs_n !== 1'b1) cs_bad++;
      if (cd_oe !== 1'b0) oe_bad++;
    end
    check("undec_no_req", vdp_cnt + aux_cnt - base, 0);
    check("undec_cs_high", cs_bad, 0);
    check("undec_oe_low", oe_bad, 0);
    idle_bus();
    repeat (4) tick();
    exp_q.push_back('{1'b1, 1'b1, 8'h3C});
    base = aux_cnt;
    A = 6'h27; cd_in = 8'h3C; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (10) tick();
    check("aux_one_req", aux_cnt - base, 1);
    idle_bus();
    repeat (5) tick();

    // rd_n and wr_n both low
    base = vdp_cnt + aux_cnt; cs_bad = 0;
    A = 6'h26; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cs_n !== 1'b1) cs_bad++;
    end
    check("both_low_no_req", vdp_cnt + aux_cnt - base, 0);
    check("both_low_cs_high", cs_bad, 0);
    idle_bus();
    repeat (4) tick();

    // Reset during HOLD of a read, strobes held across release
    exp_q.push_back('{1'b0, 1'b0, 8'h22});
    A = 6'h26; cd_in = 8'h22; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (7) tick();
    check("hold_oe_before_rst", cd_oe, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_oe_async", cd_oe, 0);
    check("rst_cs_async", cs_n, 1);
    repeat (2) tick();
    reset_n = 1'b1;
    base = vdp_cnt + aux_cnt;
    repeat (10) tick();
    check("rst_held_no_req", vdp_cnt + aux_cnt - base, 0);
    idle_bus();
    repeat (5) tick();

    // Back-to-back writes separated by one inactive clk
    base = vdp_cnt;
    exp_q.push_back('{1'b0, 1'b1, 8'h01});
    A = 6'h26; cd_in = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (8) tick();
    idle_bus();
    tick();
    exp_q.push_back('{1'b0, 1'b1, 8'h02});
    cd_in = 8'h02; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (8) tick();
    idle_bus();
    repeat (5) tick();
    check("b2b_two_reqs", vdp_cnt - base, 2);

    // Half-clk strobe glitch
    base = vdp_cnt + aux_cnt;
    exp_q.push_back('{1'b0, 1'b1, 8'h77});
    A = 6'h26; cd_in = 8'h77;
    #2 iorq_n = 1'b0; wr_n = 1'b0;
    #5 idle_bus();
    repeat (10) tick();
    check("glitch_at_most_one", (vdp_cnt + aux_cnt - base) <= 1, 1);
    if (vdp_cnt + aux_cnt == base) exp_q.delete();

    check("sb_empty", exp_q.size(), 0);
    check("same_base_no_aux", aux2_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
